// File: rtl/prio_arb4.sv
// prio_arb4: four-requester priority arbiter with round-robin tie-break and
// bounded grant tenure.
//
// Parameters
//   HOLD_MAX  maximum consecutive grant cycles per tenure (2..16)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req[3:0]     request lines, bit i belongs to requester i
//   prio0..prio3 unsigned priority per requester, larger wins
//   gnt[3:0]     registered grant, one-hot or zero
//   gnt_idx[1:0] registered index of the granted requester (holds when gnt is 0)
//   busy         registered, high whenever the arbiter is not idle
//
// Sequence: IDLE arbitrates on the first edge that sees any request, GRANT
// holds the winner until its request drops or the tenure limit is reached,
// RELEASE inserts one dead cycle before the next arbitration.

module prio_arb4 #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [2:0] prio0,
    input  logic [2:0] prio1,
    input  logic [2:0] prio2,
    input  logic [2:0] prio3,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       busy
);

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned PRIO_W    = 3;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned CNT_W     = 4;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   hold_cnt;

    logic [PRIO_W-1:0]  prio_vec [NUM_REQ];
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [PRIO_W-1:0]  win_prio;
    logic               tenure_end;

    assign prio_vec[0] = prio0;
    assign prio_vec[1] = prio1;
    assign prio_vec[2] = prio2;
    assign prio_vec[3] = prio3;

    // Winner select: scan upward from rr_ptr; strict '>' keeps the first
    // tied requester in scan order, which gives the round-robin tie-break.
    always_comb begin : winner_pick
        logic [IDX_W-1:0] cand;
        cand      = '0;
        win_idx   = rr_ptr;
        win_found = 1'b0;
        win_prio  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = rr_ptr + IDX_W'(k);
            if (req[cand] && (!win_found || (prio_vec[cand] > win_prio))) begin
                win_found = 1'b1;
                win_prio  = prio_vec[cand];
                win_idx   = cand;
            end
        end
    end

    // Tenure ends when the holder lets go or the hold limit is reached.
    assign tenure_end = !req[gnt_idx] || (hold_cnt == HOLD_LAST);

    // Arbiter FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_idx  <= '0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt      <= NUM_REQ'(1) << win_idx;
                        gnt_idx  <= win_idx;
                        rr_ptr   <= win_idx + IDX_W'(1);
                        hold_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= GRANT;
                    end else begin
                        gnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                GRANT: begin
                    if (tenure_end) begin
                        gnt   <= '0;
                        busy  <= 1'b1;
                        state <= RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_arb4.sv
// Self-checking bench for prio_arb4: directed scenarios followed by random
// traffic, all compared cycle by cycle against a tenure-level reference model.

module tb_prio_arb4;

    localparam int unsigned HOLD_MAX = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [2:0] prio_a [4];
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;

    int errors;
    int checks;

    // Reference model: phase 0 idle, 1 granted, 2 dead cycle after release.
    int         m_phase;
    int         m_tenure;
    int         m_rr;
    logic [3:0] m_gnt;
    logic [1:0] m_idx;
    logic       m_busy;

    prio_arb4 #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .prio0   (prio_a[0]),
        .prio1   (prio_a[1]),
        .prio2   (prio_a[2]),
        .prio3   (prio_a[3]),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Highest priority among requesters, ties broken by first index from rr.
    function automatic int pick(input logic [3:0] r, input int rr);
        int best;
        int j;
        best = -1;
        for (int i = 0; i < 4; i++)
            if (r[i] && int'(prio_a[i]) > best) best = int'(prio_a[i]);
        for (int k = 0; k < 4; k++) begin
            j = (rr + k) % 4;
            if (r[j] && int'(prio_a[j]) == best) return j;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_tenure = 0;
        m_rr     = 0;
        m_gnt    = 4'b0000;
        m_idx    = 2'd0;
        m_busy   = 1'b0;
    endtask

    task automatic model_step();
        int w;
        if (!rst_n) begin
            model_reset();
            return;
        end
        case (m_phase)
            0: if (req != 4'b0000) begin
                w        = pick(req, m_rr);
                m_idx    = 2'(w);
                m_gnt    = 4'(1 << w);
                m_rr     = (w + 1) % 4;
                m_tenure = 1;
                m_phase  = 1;
            end
            1: if (!req[m_idx] || m_tenure == int'(HOLD_MAX)) begin
                m_gnt   = 4'b0000;
                m_phase = 2;
            end else begin
                m_tenure++;
            end
            default: m_phase = 0;
        endcase
        m_busy = (m_phase != 0);
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("gnt", gnt, m_gnt);
        check("gnt_idx", 4'(gnt_idx), 4'(m_idx));
        check("busy", 4'(busy), 4'(m_busy));
        check("onehot", 4'($countones(gnt) <= 1), 4'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_prio(input int p0, input int p1, input int p2, input int p3);
        prio_a[0] = 3'(p0);
        prio_a[1] = 3'(p1);
        prio_a[2] = 3'(p2);
        prio_a[3] = 3'(p3);
    endtask

    task automatic go_idle();
        req = 4'b0000;
        repeat (3) tick();
    endtask

    initial begin
        int exp_order [5];
        errors = 0;
        checks = 0;
        exp_order = '{0, 1, 2, 3, 0};

        // Reset state
        rst_n = 1'b0;
        req   = 4'b0000;
        set_prio(0, 0, 0, 0);
        model_reset();
        #1;
        compare_all();
        tick();
        tick();
        rst_n = 1'b1;

        // Idle with no requests for 20 cycles
        repeat (20) begin
            tick();
            check("idle_gnt", gnt, 4'b0000);
            check("idle_busy", 4'(busy), 4'd0);
        end

        // Round-robin on full tie, each grant released after one cycle
        set_prio(5, 5, 5, 5);
        for (int i = 0; i < 5; i++) begin
            req = 4'b1111;
            tick();
            check("rr_order", 4'(gnt_idx), 4'(exp_order[i]));
            check("rr_gnt", gnt, 4'(1 << exp_order[i]));
            req = 4'b1111 & ~gnt;
            tick();
            req = 4'b1111;
            tick();
            req = 4'b0000;
        end
        go_idle();

        // Max select, then next-best after the winner drops
        set_prio(1, 2, 3, 4);
        req = 4'b1111;
        tick();
        check("max_gnt", gnt, 4'b1000);
        check("max_idx", 4'(gnt_idx), 4'd3);
        req = 4'b0111;
        tick();
        check("max_gap1", gnt, 4'b0000);
        tick();
        check("max_gap2", gnt, 4'b0000);
        tick();
        check("max_next", gnt, 4'b0100);
        go_idle();

        // Mixed tie with rr_ptr = 2 (set by granting requester 1)
        set_prio(0, 0, 0, 0);
        req = 4'b0010;
        tick();
        check("mix_setup", 4'(gnt_idx), 4'd1);
        go_idle();
        set_prio(2, 4, 4, 0);
        req = 4'b0111;
        tick();
        check("mix_first", 4'(gnt_idx), 4'd2);
        // Held request times out, then re-arbitrates with the same inputs
        repeat (HOLD_MAX + 2) tick();
        check("mix_second", 4'(gnt_idx), 4'd1);
        check("mix_second_gnt", gnt, 4'b0010);
        go_idle();

        // Timeout: continuous single request
        set_prio(3, 0, 0, 0);
        req = 4'b0001;
        for (int i = 0; i < int'(HOLD_MAX); i++) begin
            tick();
            check("to_high", gnt, 4'b0001);
        end
        tick();
        check("to_gap1", gnt, 4'b0000);
        tick();
        check("to_gap2", gnt, 4'b0000);
        tick();
        check("to_again", gnt, 4'b0001);
        go_idle();

        // Priority change during grant is ignored until release
        set_prio(0, 3, 5, 1);
        req = 4'b0101;
        tick();
        check("pc_gnt", gnt, 4'b0100);
        set_prio(7, 3, 5, 1);
        repeat (3) begin
            tick();
            check("pc_hold", gnt, 4'b0100);
        end
        req = 4'b0001;
        repeat (3) tick();
        check("pc_next", gnt, 4'b0001);
        go_idle();

        // Reset in the middle of a grant
        set_prio(6, 1, 1, 1);
        req = 4'b0011;
        tick();
        tick();
        check("rst_pre", gnt, 4'b0001);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_gnt", gnt, 4'b0000);
        check("rst_busy", 4'(busy), 4'd0);
        tick();
        rst_n = 1'b1;
        set_prio(5, 5, 5, 5);
        req = 4'b1111;
        tick();
        check("rst_rr", 4'(gnt_idx), 4'd0);
        go_idle();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) begin
                req = 4'($urandom);
                set_prio(int'($urandom_range(7)), int'($urandom_range(7)),
                         int'($urandom_range(7)), int'($urandom_range(7)));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prio_arb4.md
PRIO_ARB4 -- requirements
Module: prio_arb4

Interface
REQ-001 The block SHALL have one parameter, HOLD_MAX, default 8, setting the maximum consecutive grant cycles per tenure; legal range 2..16.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-004 Port req, input, 4 bits, SHALL carry one request line per requester; bit i is requester i.
REQ-005 Ports prio0, prio1, prio2 and prio3, inputs, 3 bits each, SHALL carry the unsigned priority of requesters 0..3; a larger value means higher priority.
REQ-006 Port gnt, output, 4 bits, SHALL be the registered grant, one-hot or zero.
REQ-007 Port gnt_idx, output, 2 bits, SHALL be the registered index of the granted requester; it holds its last value when gnt is 0.
REQ-008 Port busy, output, 1 bit, SHALL be registered and high whenever the state is not IDLE.

Function
REQ-009 The block SHALL implement a three-state FSM: IDLE, GRANT and RELEASE.
REQ-010 In IDLE with req = 0, the block SHALL stay in IDLE with gnt = 0.
REQ-011 On a rising edge in IDLE with req != 0, the block SHALL:
- pick a winner among the asserted req bits;
- load gnt with the winner's one-hot code and gnt_idx with the winner's index;
- clear hold_cnt and enter GRANT.
REQ-012 Arbitration latency SHALL be 1 cycle: gnt is visible the cycle after req is first sampled high in IDLE.
REQ-013 The winner SHALL be the asserted requester with the maximum prio value.
- Only unrequested lines are excluded.
- Priorities are sampled only at the arbitration edge.
REQ-014 On a priority tie, the winner SHALL be the first tied requester found scanning upward, with wrap-around, starting from index rr_ptr.
REQ-015 rr_ptr (2 bits, wraps 3 -> 0) SHALL be loaded with (winner index + 1) mod 4 at every arbitration.
REQ-016 In GRANT, the block SHALL hold gnt and gnt_idx stable and advance hold_cnt by 1 each cycle.
REQ-017 GRANT SHALL exit to RELEASE on the first edge at which req[gnt_idx] = 0 or hold_cnt = HOLD_MAX-1.
- gnt is therefore high for at most HOLD_MAX cycles.
- If both conditions are true on the same edge, the result is the same exit.
REQ-018 Entering RELEASE, the block SHALL clear gnt to 0; RELEASE SHALL last exactly 1 cycle and always return to IDLE.
REQ-019 The minimum gap between two grants SHALL be 2 cycles with gnt = 0 (RELEASE, then IDLE arbitration).
REQ-020 While in GRANT, the block SHALL ignore changes on non-granted req bits and on all prio inputs.
REQ-021 A requester whose grant timed out while still requesting SHALL re-compete normally at the next arbitration.
REQ-022 At most one gnt bit SHALL ever be high.
REQ-023 hold_cnt SHALL be 4 bits and never exceed HOLD_MAX-1.

Reset
REQ-024 When rst_n = 0, the block SHALL immediately force:
- state = IDLE, gnt = 0, gnt_idx = 0, busy = 0;
- rr_ptr = 0, hold_cnt = 0.
REQ-025 Reset asserted mid-GRANT SHALL drop gnt immediately, without passing through RELEASE.
REQ-026 After rst_n deasserts, the first arbitration SHALL occur on the first rising edge with req != 0.

Verification
REQ-027 Max select: req=1111, prio0..3 = 1,2,3,4 -> gnt=1000 and gnt_idx=3 one cycle later; drop req[3] -> gnt=0 for 2 cycles, then gnt=0100 (prio 3 wins).
REQ-028 Tie round-robin: after reset, req=1111, all prio=5, each grant released after 1 cycle -> grant order 0,1,2,3,0.
REQ-029 Mixed tie: prio = 2,4,4,0, rr_ptr=2, req=0111 -> gnt_idx=2; next arbitration with the same inputs -> gnt_idx=1.
REQ-030 Timeout: HOLD_MAX=8, req=0001 held high -> gnt=0001 for exactly 8 cycles, 0 for 2 cycles, then 0001 again.
REQ-031 Idle and reset: req=0000 for 20 cycles -> gnt=0 and busy=0 throughout; rst_n pulsed low during GRANT -> gnt=0 and busy=0 within the same cycle, rr_ptr=0.
REQ-032 Priority change during grant: prio0 raised from 0 to 7 while requester 2 is granted -> gnt unchanged until requester 2 releases; requester 0 wins the next arbitration.
